fetch_unit: RTL

Instruction-fetch stage directly upstream of the instruction decoder. Owns the program counter and the instruction-memory address ports, and presents the current instruction word and its trailing immediate word (`N`) to the decoder every cycle. It applies the decoder's PC-update controls (`cnt_en`, `pc_sload`, `new_pc`) and handles the boot cycle, external hold/single-step, and the halted state.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_pc_reg.sv | 47 ++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode/instruction constants and the fetch state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [4:0]  OPC_NOP   = 5'b00000;
    localparam logic [4:0]  OPC_STP   = 5'b11111;

    localparam logic [15:0] INSTR_NOP = 16'h0000;
    localparam logic [15:0] INSTR_STP = 16'hF800;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    function automatic logic is_stp(input logic [15:0] word);
        return word[15:11] == OPC_STP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter with freeze > sload > increment priority and
//               16-bit wrap. Resets to RESET_PC + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic        sload,
    input  logic        inc,
    input  logic [15:0] new_pc,
    output logic [15:0] pc
);

    localparam logic [15:0] PC_AFTER_RESET = RESET_PC + 16'd1;

    logic [15:0] pc_d;
    logic [15:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (!freeze) begin
            if (sload) begin
                pc_d = new_pc;
            end else if (inc) begin
                pc_d = pc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_AFTER_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: boot cycle, run/hold/halt control,
//               memory address muxing and PC update. Optional retired-
//               instruction counter enabled by FETCH_RETIRE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic [15:0] imem_q1,
    input  logic [15:0] imem_q2,
    input  logic [15:0] dec_instr_addr1,
    input  logic [15:0] dec_instr_addr2,
    input  logic        cnt_en,
    input  logic        pc_sload,
    input  logic [15:0] new_pc,
    output logic [15:0] imem_addr1,
    output logic [15:0] imem_addr2,
    output logic [15:0] instr,
    output logic [15:0] N,
    output logic [15:0] pc,
    output logic        halted
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    import cpu_pkg::*;

    localparam logic [15:0] BOOT_ADDR2 = RESET_PC + 16'd1;

    fetch_state_t state_d;
    fetch_state_t state_q;
    logic         halted_d;
    logic         halted_q;
    logic [15:0]  saved_addr1_d;
    logic [15:0]  saved_addr1_q;
    logic [15:0]  saved_addr2_d;
    logic [15:0]  saved_addr2_q;
    logic         w_pc_freeze;

    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        saved_addr1_d = saved_addr1_q;
        saved_addr2_d = saved_addr2_q;
        w_pc_freeze   = 1'b1;
        instr         = INSTR_NOP;
        N             = 16'h0000;
        imem_addr1    = saved_addr1_q;
        imem_addr2    = saved_addr2_q;

        case (state_q)
            ST_BOOT: begin
                imem_addr1 = RESET_PC;
                imem_addr2 = BOOT_ADDR2;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                instr         = imem_q1;
                N             = imem_q2;
                imem_addr1    = dec_instr_addr1;
                imem_addr2    = dec_instr_addr2;
                saved_addr1_d = dec_instr_addr1;
                saved_addr2_d = dec_instr_addr2;
                // Hold outranks STP; STP still lets its own PC update through.
                if (hold) begin
                    state_d = ST_HOLD;
                end else begin
                    w_pc_freeze = 1'b0;
                    if (is_stp(imem_q1)) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!hold) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                instr = INSTR_STP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            halted_q      <= 1'b0;
            saved_addr1_q <= RESET_PC;
            saved_addr2_q <= BOOT_ADDR2;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            saved_addr1_q <= saved_addr1_d;
            saved_addr2_q <= saved_addr2_d;
        end
    end

    assign halted = halted_q;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .freeze (w_pc_freeze),
        .sload  (pc_sload),
        .inc    (cnt_en),
        .new_pc (new_pc),
        .pc     (pc)
    );

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retired_d;
    logic [31:0] retired_q;

    always_comb begin
        retired_d = retired_q;
        if ((state_q == ST_RUN) && !is_stp(imem_q1)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule
`default_nettype wire
